// File: rtl/cache_control_nway.sv
`default_nettype none
//==============================================================================
// Module     : cache_control_nway
// Description: N-way set-associative cache controller with write-back,
//              line refill, tree-PLRU replacement and hit/miss statistics.
// Revision   : 1.0 - initial release
//==============================================================================

module cache_control_nway #(
   parameter int WAYS  = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             read_array,
   input  logic             write_array,
   input  logic             pmem_resp,
   input  logic [WAYS-1:0]  hit,
   input  logic [WAYS-1:0]  valid,
   input  logic [WAYS-1:0]  dirty,
   input  logic [WAYS-2:0]  plru_in,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   output logic             pmem_select,
   output logic             data_select,
   output logic             dirty_select,
   output logic [WAYS-1:0]  way_sel,
   output logic [1:0]       write_mode,
   output logic [WAYS-1:0]  valid_load,
   output logic [WAYS-1:0]  tag_load,
   output logic [WAYS-1:0]  dirty_load,
   output logic             plru_load,
   output logic [WAYS-2:0]  plru_out,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int IDX_W = $clog2(WAYS);

   typedef enum logic [1:0] {
      ST_ACCESS     = 2'd0,
      ST_WRITE_BACK = 2'd1,
      ST_ALLOCATE   = 2'd2
   } state_t;

   state_t           r_state, w_next;
   logic [IDX_W-1:0] r_victim;
   logic [IDX_W-1:0] w_victim, w_hit_idx, w_inv_idx, w_plru_idx;
   logic [WAYS-1:0]  w_hit_oh, w_latched_oh;
   logic [WAYS-2:0]  w_plru_upd;
   logic             w_match, w_req, w_hit_inc, w_miss_inc;
   logic [CNT_W-1:0] r_hit_count, r_miss_count;

   assign w_req        = read_array | write_array;
   assign w_hit_oh     = WAYS'(1) << w_hit_idx;
   assign w_latched_oh = WAYS'(1) << r_victim;
   assign hit_count    = r_hit_count;
   assign miss_count   = r_miss_count;

   // Descending scans leave the lowest matching index behind.
   always_comb begin
      w_hit_idx = '0;
      w_inv_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit[i])   w_hit_idx = IDX_W'(i);
         if (!valid[i]) w_inv_idx = IDX_W'(i);
      end
   end

   // A way is the PLRU victim when every node on its root-to-leaf path points toward it.
   always_comb begin
      w_plru_idx = '0;
      w_match    = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         w_match = 1'b1;
         for (int l = 0; l < IDX_W; l++) begin
            if (plru_in[(1 << l) - 1 + (w >> (IDX_W - l))] != (((w >> (IDX_W - 1 - l)) & 1) == 1))
               w_match = 1'b0;
         end
         if (w_match) w_plru_idx = IDX_W'(w);
      end
   end

   always_comb begin
      w_plru_upd = plru_in;
      for (int w = 0; w < WAYS; w++) begin
         if (w_hit_idx == IDX_W'(w)) begin
            for (int l = 0; l < IDX_W; l++)
               w_plru_upd[(1 << l) - 1 + (w >> (IDX_W - l))] = (((w >> (IDX_W - 1 - l)) & 1) == 0);
         end
      end
   end

   assign w_victim = (&valid) ? w_plru_idx : w_inv_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_ACCESS;
         r_victim     <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_miss_inc) r_victim <= w_victim;
         if (w_hit_inc && (r_hit_count != '1))
            r_hit_count <= r_hit_count + CNT_W'(1);
         if (w_miss_inc && (r_miss_count != '1))
            r_miss_count <= r_miss_count + CNT_W'(1);
      end
   end

   always_comb begin
      w_next       = r_state;
      w_hit_inc    = 1'b0;
      w_miss_inc   = 1'b0;
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_select  = 1'b0;
      data_select  = 1'b1;
      dirty_select = 1'b0;
      way_sel      = '0;
      write_mode   = 2'b00;
      valid_load   = '0;
      tag_load     = '0;
      dirty_load   = '0;
      plru_load    = 1'b0;
      plru_out     = '0;
      // Outputs are gated by reset so memory requests drop without waiting for an edge.
      if (rst) begin
         case (r_state)
            ST_ACCESS: begin
               if (w_req && (|hit)) begin
                  mem_resp  = 1'b1;
                  plru_load = 1'b1;
                  plru_out  = w_plru_upd;
                  w_hit_inc = 1'b1;
                  if (write_array) begin
                     way_sel      = w_hit_oh;
                     write_mode   = 2'b01;
                     data_select  = 1'b0;
                     dirty_select = 1'b1;
                     dirty_load   = w_hit_oh;
                  end
               end else if (w_req) begin
                  w_miss_inc = 1'b1;
                  w_next     = (valid[w_victim] && dirty[w_victim]) ? ST_WRITE_BACK : ST_ALLOCATE;
               end
            end
            ST_WRITE_BACK: begin
               pmem_write  = 1'b1;
               pmem_select = 1'b1;
               way_sel     = w_latched_oh;
               if (pmem_resp) begin
                  dirty_load = w_latched_oh;
                  w_next     = ST_ALLOCATE;
               end
            end
            ST_ALLOCATE: begin
               pmem_read = 1'b1;
               way_sel   = w_latched_oh;
               if (pmem_resp) begin
                  write_mode = 2'b10;
                  valid_load = w_latched_oh;
                  tag_load   = w_latched_oh;
                  dirty_load = w_latched_oh;
                  w_next     = ST_ACCESS;
               end
            end
            default: w_next = ST_ACCESS;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_control_nway.sv
`default_nettype none
//==============================================================================
// Module     : tb_cache_control_nway
// Description: Self-checking bench for cache_control_nway (WAYS=4, CNT_W=4).
// Revision   : 1.0 - initial release
//==============================================================================

module tb_cache_control_nway;

   localparam int WAYS  = 4;
   localparam int CNT_W = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       read_array = 1'b0, write_array = 1'b0, pmem_resp = 1'b0;
   logic [3:0] hit = '0, valid = '0, dirty = '0;
   logic [2:0] plru_in = '0;
   logic       mem_resp, pmem_read, pmem_write, pmem_select, data_select, dirty_select;
   logic [3:0] way_sel, valid_load, tag_load, dirty_load;
   logic [1:0] write_mode;
   logic       plru_load;
   logic [2:0] plru_out;
   logic [3:0] hit_count, miss_count;

   cache_control_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .read_array(read_array), .write_array(write_array),
      .pmem_resp(pmem_resp), .hit(hit), .valid(valid), .dirty(dirty), .plru_in(plru_in),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_select(pmem_select), .data_select(data_select), .dirty_select(dirty_select),
      .way_sel(way_sel), .write_mode(write_mode), .valid_load(valid_load),
      .tag_load(tag_load), .dirty_load(dirty_load), .plru_load(plru_load),
      .plru_out(plru_out), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [27:0] obs;
   assign obs = {mem_resp, pmem_read, pmem_write, pmem_select, data_select, dirty_select,
                 way_sel, write_mode, valid_load, tag_load, dirty_load, plru_load, plru_out};

   // expected outputs
   logic       e_mem_resp, e_pmem_read, e_pmem_write, e_pmem_select, e_data_select, e_dirty_select;
   logic [3:0] e_way_sel, e_valid_load, e_tag_load, e_dirty_load;
   logic [1:0] e_write_mode;
   logic       e_plru_load;
   logic [2:0] e_plru_out;

   // reference model state: 0 idle/access, 1 writing back, 2 refilling
   int m_state, m_victim, m_hits, m_misses, m_next;

   function automatic logic [27:0] exp_pack();
      return {e_mem_resp, e_pmem_read, e_pmem_write, e_pmem_select, e_data_select, e_dirty_select,
              e_way_sel, e_write_mode, e_valid_load, e_tag_load, e_dirty_load, e_plru_load, e_plru_out};
   endfunction

   function automatic logic [2:0] ref_plru_update(logic [2:0] p, int w);
      int node = 0;
      int d;
      for (int l = 1; l >= 0; l--) begin
         d = (w >> l) & 1;
         p[node] = (d == 0);
         node = 2 * node + 1 + d;
      end
      return p;
   endfunction

   function automatic int ref_victim(logic [3:0] vld, logic [2:0] p);
      int node = 0;
      for (int i = 0; i < 4; i++) if (!vld[i]) return i;
      for (int l = 0; l < 2; l++) node = 2 * node + 1 + int'(p[node]);
      return node - 3;
   endfunction

   function automatic int lowest(logic [3:0] h);
      for (int i = 0; i < 4; i++) if (h[i]) return i;
      return 0;
   endfunction

   task automatic exp_idle();
      {e_mem_resp, e_pmem_read, e_pmem_write, e_pmem_select, e_dirty_select} = '0;
      e_data_select = 1'b1;
      e_way_sel = '0; e_write_mode = '0; e_valid_load = '0; e_tag_load = '0;
      e_dirty_load = '0; e_plru_load = 1'b0; e_plru_out = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [3:0] h, input logic [3:0] v,
                        input logic [3:0] d, input logic [2:0] p, input logic resp);
      read_array = r; write_array = w; hit = h; valid = v; dirty = d; plru_in = p; pmem_resp = resp;
      #1;
   endtask

   // Expected combinational outputs and next model state from current inputs.
   task automatic predict();
      int h;
      int v;
      exp_idle();
      m_next = m_state;
      if (rst) begin
         if (m_state == 0 && (read_array || write_array)) begin
            if (hit != 0) begin
               h = lowest(hit);
               e_mem_resp = 1'b1; e_plru_load = 1'b1; e_plru_out = ref_plru_update(plru_in, h);
               if (write_array) begin
                  e_way_sel = 4'(1 << h); e_write_mode = 2'b01; e_data_select = 1'b0;
                  e_dirty_select = 1'b1; e_dirty_load = 4'(1 << h);
               end
            end else begin
               v = ref_victim(valid, plru_in);
               m_next = (valid[v] && dirty[v]) ? 1 : 2;
            end
         end else if (m_state == 1) begin
            e_pmem_write = 1'b1; e_pmem_select = 1'b1; e_way_sel = 4'(1 << m_victim);
            if (pmem_resp) begin e_dirty_load = 4'(1 << m_victim); m_next = 2; end
         end else if (m_state == 2) begin
            e_pmem_read = 1'b1; e_way_sel = 4'(1 << m_victim);
            if (pmem_resp) begin
               e_write_mode = 2'b10;
               e_valid_load = 4'(1 << m_victim); e_tag_load = 4'(1 << m_victim);
               e_dirty_load = 4'(1 << m_victim); m_next = 0;
            end
         end
      end
   endtask

   task automatic model_commit();
      if (m_state == 0 && (read_array || write_array)) begin
         if (hit != 0) begin
            if (m_hits < 15) m_hits++;
         end else begin
            if (m_misses < 15) m_misses++;
            m_victim = ref_victim(valid, plru_in);
         end
      end
      m_state = m_next;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1, 1, 4'b0000, 4'b1111, 4'b1111, 3'b101, 1);
      exp_idle();
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL reset_outputs: got %h want %h", obs, exp_pack());
      end
      tick();
      n_vec++;
      if ({hit_count, miss_count} !== 8'h00) begin
         n_err++; $display("FAIL reset_counters: got %h/%h want 0/0", hit_count, miss_count);
      end
      rst = 1'b1;
   endtask

   task automatic test_read_hit();
      drive(1, 0, 4'b0100, 4'b1111, 4'b0000, 3'b000, 0);
      exp_idle(); e_mem_resp = 1'b1; e_plru_load = 1'b1; e_plru_out = 3'b100;
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL read_hit: got %h want %h", obs, exp_pack());
      end
      tick();
      n_vec++;
      if (hit_count !== 4'd1) begin
         n_err++; $display("FAIL read_hit_count: got %0d want 1", hit_count);
      end
   endtask

   task automatic test_write_hit();
      drive(0, 1, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0);
      exp_idle(); e_mem_resp = 1'b1; e_plru_load = 1'b1; e_plru_out = ref_plru_update(3'b000, 0);
      e_way_sel = 4'b0001; e_write_mode = 2'b01; e_data_select = 1'b0;
      e_dirty_select = 1'b1; e_dirty_load = 4'b0001;
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL write_hit: got %h want %h", obs, exp_pack());
      end
      tick();
      // both requests high with multiple hits: write to the lowest hit way
      drive(1, 1, 4'b1010, 4'b1111, 4'b0000, 3'b110, 0);
      exp_idle(); e_mem_resp = 1'b1; e_plru_load = 1'b1; e_plru_out = ref_plru_update(3'b110, 1);
      e_way_sel = 4'b0010; e_write_mode = 2'b01; e_data_select = 1'b0;
      e_dirty_select = 1'b1; e_dirty_load = 4'b0010;
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL both_req_multi_hit: got %h want %h", obs, exp_pack());
      end
      tick();
      n_vec++;
      if (hit_count !== 4'd3) begin
         n_err++; $display("FAIL write_hit_count: got %0d want 3", hit_count);
      end
   endtask

   task automatic test_writeback_miss();
      drive(1, 0, 4'b0000, 4'b1111, 4'b0100, 3'b001, 0);
      exp_idle();
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL miss_access: got %h want %h", obs, exp_pack());
      end
      tick();
      n_vec++;
      if (miss_count !== 4'd1) begin
         n_err++; $display("FAIL miss_count1: got %0d want 1", miss_count);
      end
      for (int c = 0; c < 3; c++) begin
         drive(1, 0, 4'b0000, 4'b1111, 4'b0100, 3'b000, logic'(c == 2));
         exp_idle(); e_pmem_write = 1'b1; e_pmem_select = 1'b1; e_way_sel = 4'b0100;
         if (c == 2) e_dirty_load = 4'b0100;
         n_vec++;
         if (obs !== exp_pack()) begin
            n_err++; $display("FAIL write_back c%0d: got %h want %h", c, obs, exp_pack());
         end
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         drive(1, 0, 4'b0000, 4'b1111, 4'b0100, 3'b000, logic'(c == 1));
         exp_idle(); e_pmem_read = 1'b1; e_way_sel = 4'b0100;
         if (c == 1) begin
            e_write_mode = 2'b10; e_valid_load = 4'b0100; e_tag_load = 4'b0100; e_dirty_load = 4'b0100;
         end
         n_vec++;
         if (obs !== exp_pack()) begin
            n_err++; $display("FAIL allocate c%0d: got %h want %h", c, obs, exp_pack());
         end
         tick();
      end
      drive(1, 0, 4'b0100, 4'b1111, 4'b0000, 3'b001, 0);
      exp_idle(); e_mem_resp = 1'b1; e_plru_load = 1'b1; e_plru_out = ref_plru_update(3'b001, 2);
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL refill_hit: got %h want %h", obs, exp_pack());
      end
      tick();
      n_vec++;
      if ({hit_count, miss_count} !== {4'd4, 4'd1}) begin
         n_err++; $display("FAIL refill_counts: got %0d/%0d want 4/1", hit_count, miss_count);
      end
   endtask

   task automatic test_invalid_victim();
      drive(0, 1, 4'b0000, 4'b1011, 4'b1111, 3'b000, 0);
      tick();
      drive(0, 1, 4'b0000, 4'b1011, 4'b1111, 3'b000, 0);
      exp_idle(); e_pmem_read = 1'b1; e_way_sel = 4'b0100;
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL invalid_victim: got %h want %h", obs, exp_pack());
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b0;
      #1;
      exp_idle();
      n_vec++;
      if (obs !== exp_pack() || hit_count !== 4'd0 || miss_count !== 4'd0) begin
         n_err++; $display("FAIL reset_mid: got %h cnt %0d/%0d want %h cnt 0/0", obs, hit_count, miss_count, exp_pack());
      end
      tick();
      rst = 1'b1;
      drive(1, 0, 4'b0010, 4'b1111, 4'b0000, 3'b000, 0);
      exp_idle(); e_mem_resp = 1'b1; e_plru_load = 1'b1; e_plru_out = 3'b001;
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL after_reset_hit: got %h want %h", obs, exp_pack());
      end
      tick();
      n_vec++;
      if (hit_count !== 4'd1) begin
         n_err++; $display("FAIL after_reset_count: got %0d want 1", hit_count);
      end
   endtask

   task automatic test_deassert();
      drive(1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0);
      tick();
      drive(0, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0);
      exp_idle(); e_pmem_read = 1'b1; e_way_sel = 4'b0001;
      n_vec++;
      if (obs !== exp_pack()) begin
         n_err++; $display("FAIL deassert_alloc: got %h want %h", obs, exp_pack());
      end
      tick();
      drive(0, 0, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1);
      tick();
      drive(0, 0, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0);
      exp_idle();
      n_vec++;
      if (obs !== exp_pack() || hit_count !== 4'd1) begin
         n_err++; $display("FAIL deassert_return: got %h hits %0d want %h hits 1", obs, hit_count, exp_pack());
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 4'b1000, 4'b1111, 4'b0000, 3'($urandom), 0);
         tick();
      end
      n_vec++;
      if (hit_count !== 4'd15) begin
         n_err++; $display("FAIL hit_saturate: got %0d want 15", hit_count);
      end
   endtask

   task automatic test_random();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      m_state = 0; m_victim = 0; m_hits = 0; m_misses = 0;
      for (int i = 0; i < 600; i++) begin
         drive(logic'($urandom % 2), logic'($urandom % 4 == 0),
               ($urandom % 2) ? 4'($urandom) : 4'b0000,
               ($urandom % 3 == 0) ? 4'($urandom) : 4'b1111,
               4'($urandom), 3'($urandom), logic'($urandom % 3 == 0));
         predict();
         n_vec++;
         if (obs !== exp_pack()) begin
            n_err++; $display("FAIL random_out %0d: got %h want %h", i, obs, exp_pack());
         end
         model_commit();
         tick();
         n_vec++;
         if (hit_count !== 4'(m_hits) || miss_count !== 4'(m_misses)) begin
            n_err++; $display("FAIL random_cnt %0d: got %0d/%0d want %0d/%0d", i, hit_count, miss_count, m_hits, m_misses);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_read_hit();
      test_write_hit();
      test_writeback_miss();
      test_invalid_victim();
      test_reset_mid();
      test_deassert();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cache_control_nway.md
CACHE_CONTROL_NWAY -- requirements
Module: cache_control_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity; power of two, 2..8.
REQ-002 SHALL have parameter CNT_W, default 32: width of hit/miss statistic counters.
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  sole clock; all state changes on rising edge
  rst  in  1  reset, asynchronous, active-low
  read_array  in  1  CPU read request, held until mem_resp
  write_array  in  1  CPU write request, held until mem_resp
  pmem_resp  in  1  physical-memory transfer complete
  hit  in  WAYS  per-way tag match (valid & tag equal)
  valid  in  WAYS  per-way valid bits of indexed set
  dirty  in  WAYS  per-way dirty bits of indexed set
  plru_in  in  WAYS-1  tree-PLRU bits of indexed set
  mem_resp  out  1  CPU request complete
  pmem_read / pmem_write  out  1  line fill / line write-back request
  pmem_select  out  1  1 = victim tag+index address, 0 = CPU address
  data_select  out  1  1 = pmem_rdata into data arrays, 0 = mem_wdata
  dirty_select  out  1  value written to dirty array
  way_sel  out  WAYS  one-hot way targeted by data/dirty/tag writes and write-back mux
  write_mode  out  2  00 none, 01 mem_byte_enable256, 10 full line
  valid_load / tag_load / dirty_load  out  WAYS  per-way array load strobes
  plru_load  out  1  write plru_out to PLRU array of indexed set
  plru_out  out  WAYS-1  updated PLRU bits
  hit_count / miss_count  out  CNT_W  statistics

Function
REQ-004 SHALL implement states ACCESS, WRITE_BACK, ALLOCATE; all outputs combinational from state and inputs except counters and latched victim.
REQ-005 Request = read_array | write_array; both high SHALL be treated as write.
REQ-006 Hit = |hit; multiple hit bits SHALL select lowest-index way.
REQ-007 ACCESS read hit: mem_resp=1 same cycle, stay ACCESS.
REQ-008 ACCESS write hit: mem_resp=1, way_sel=hit way, write_mode=01, data_select=0, dirty_select=1, dirty_load[hit way]=1, stay ACCESS.
REQ-009 Any ACCESS hit: plru_load=1, plru_out = plru_in updated to point away from hit way; hit_count += 1.
REQ-010 PLRU tree: node i children 2i+1/2i+2; bit 0 = victim in left subtree, 1 = right; update sets every node on hit way's path to point to the other subtree, other bits unchanged.
REQ-011 ACCESS miss: victim = lowest-index way with valid=0, else PLRU victim; victim latched on edge; miss_count += 1; next = WRITE_BACK if valid[v]&dirty[v], else ALLOCATE.
REQ-012 WRITE_BACK: pmem_write=1, pmem_select=1, way_sel=latched victim; on pmem_resp: dirty_load[v]=1, dirty_select=0, next ALLOCATE.
REQ-013 ALLOCATE: pmem_read=1, pmem_select=0, way_sel=victim; on pmem_resp: write_mode=10, data_select=1, valid_load/tag_load/dirty_load[v]=1, dirty_select=0, next ACCESS.
REQ-014 After refill, request SHALL be serviced as a hit in ACCESS next cycle (no mem_resp from ALLOCATE).
REQ-015 Request deasserted mid-miss: transfer SHALL complete; return to ACCESS, no mem_resp.
REQ-016 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-017 Defaults when not driven: all strobes/requests 0, data_select=1, write_mode=00, way_sel=0, plru_out=0.

Reset
REQ-018 rst low SHALL asynchronously force state ACCESS, victim 0, counters 0; pmem_read/pmem_write drop immediately, including mid-transfer.
REQ-019 While rst low every output SHALL be 0 except data_select=1; first request after release is serviced normally.

Verification
REQ-020 WAYS=4, read, hit=0100, plru_in=000 -> mem_resp=1 same cycle, plru_load=1, plru_out=001 (b0=0,b2=1), hit_count=1.
REQ-021 Write, hit=0001 -> write_mode=01, data_select=0, dirty_load=0001, dirty_select=1, mem_resp=1.
REQ-022 Read miss, valid=1111, dirty=0100, plru_in=100 -> victim 2; WRITE_BACK until pmem_resp, ALLOCATE, load strobes 0100, then mem_resp next ACCESS cycle; miss_count=1.
REQ-023 Miss, valid=1011 -> victim way 2 (invalid preferred), goes straight to ALLOCATE.
REQ-024 rst low during ALLOCATE with pmem_read=1 -> pmem_read=0 before next edge, state ACCESS, counters 0.
REQ-025 CNT_W=4, 20 consecutive hits -> hit_count holds at 15.
